// File: rtl/aclk_multi_alarm.sv
// rtl/aclk_multi_alarm.sv - BCD 24h alarm clock with prescaler, NUM_ALARMS alarms and ring FSM
// Optional snooze support is built when ACLK_SNOOZE_EN is defined.
module aclk_multi_alarm #(
    parameter int TICKS_PER_SEC = 10,
    parameter int NUM_ALARMS    = 4,
    parameter int RING_SECS     = 60,
    parameter int SNOOZE_MIN    = 5,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            H_in1,
    input  logic [3:0]            H_in0,
    input  logic [3:0]            M_in1,
    input  logic [3:0]            M_in0,
    input  logic                  LD_time,
    input  logic                  LD_alarm,
    input  logic [AW-1:0]         alarm_sel,
    input  logic [NUM_ALARMS-1:0] AL_ON,
    input  logic                  STOP_al,
    input  logic                  snooze,
    output logic [1:0]            H_out1,
    output logic [3:0]            H_out0,
    output logic [3:0]            M_out1,
    output logic [3:0]            M_out0,
    output logic [3:0]            S_out1,
    output logic [3:0]            S_out0,
    output logic                  ring,
    output logic [AW-1:0]         ring_id,
    output logic                  ld_err
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int CW = 12;

`ifdef ACLK_SNOOZE_EN
    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RING} state_t;
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    state_t          state;
    logic [PW-1:0]   presc;
    logic [CW-1:0]   sec_cnt;
    logic [13:0]     alarm [NUM_ALARMS];
    logic            sec_tick, new_minute, digits_ok, sel_ok, load_t, hit, on_cur;
    logic [AW-1:0]   hit_id;
    logic [1:0]      n_h1;
    logic [3:0]      n_h0, n_m1, n_m0, n_s1, n_s0;

    assign sec_tick  = (presc == PW'(TICKS_PER_SEC - 1));
    assign digits_ok = (H_in0 <= 4'd9) && (M_in1 <= 4'd5) && (M_in0 <= 4'd9) &&
                       ((H_in1 < 2'd2) || (H_in1 == 2'd2 && H_in0 <= 4'd3));
    assign sel_ok    = ({1'b0, alarm_sel} < (AW + 1)'(NUM_ALARMS));
    assign load_t    = LD_time && digits_ok;

    // One-second BCD increment with per-digit carry and 23:59:59 wrap
    always_comb begin
        {n_h1, n_h0, n_m1, n_m0, n_s1, n_s0} = {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
        if (S_out0 != 4'd9) begin
            n_s0 = S_out0 + 4'd1;
        end else begin
            n_s0 = 4'd0;
            if (S_out1 != 4'd5) begin
                n_s1 = S_out1 + 4'd1;
            end else begin
                n_s1 = 4'd0;
                if (M_out0 != 4'd9) begin
                    n_m0 = M_out0 + 4'd1;
                end else begin
                    n_m0 = 4'd0;
                    if (M_out1 != 4'd5) begin
                        n_m1 = M_out1 + 4'd1;
                    end else begin
                        n_m1 = 4'd0;
                        if (H_out1 == 2'd2 && H_out0 == 4'd3) begin
                            n_h1 = 2'd0;
                            n_h0 = 4'd0;
                        end else if (H_out0 == 4'd9) begin
                            n_h0 = 4'd0;
                            n_h1 = H_out1 + 2'd1;
                        end else begin
                            n_h0 = H_out0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        on_cur = 1'b0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (AL_ON[i] && alarm[i] == {H_out1, H_out0, M_out1, M_out0}) begin
                hit    = 1'b1;
                hit_id = AW'(i);
            end
            if (ring_id == AW'(i))
                on_cur = AL_ON[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc      <= '0;
            {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0} <= '0;
            new_minute <= 1'b0;
            ld_err     <= 1'b0;
            for (int i = 0; i < NUM_ALARMS; i++)
                alarm[i] <= '0;
        end else begin
            ld_err <= (LD_time && !digits_ok) || (!LD_time && LD_alarm && !(digits_ok && sel_ok));
            if (load_t) begin
                presc      <= '0;
                {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0} <= {H_in1, H_in0, M_in1, M_in0, 8'h00};
                new_minute <= 1'b0;
            end else begin
                presc      <= sec_tick ? '0 : presc + PW'(1);
                new_minute <= sec_tick && S_out1 == 4'd5 && S_out0 == 4'd9;
                if (sec_tick)
                    {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0} <= {n_h1, n_h0, n_m1, n_m0, n_s1, n_s0};
            end
            for (int i = 0; i < NUM_ALARMS; i++)
                if (!LD_time && LD_alarm && digits_ok && sel_ok && alarm_sel == AW'(i))
                    alarm[i] <= {H_in1, H_in0, M_in1, M_in0};
        end
    end

    // sec_cnt counts completed seconds in the current RING or SNOOZE period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ring    <= 1'b0;
            ring_id <= '0;
            sec_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_minute && hit) begin
                        state   <= RING;
                        ring    <= 1'b1;
                        ring_id <= hit_id;
                        sec_cnt <= '0;
                    end
                end
                RING: begin
                    if (STOP_al || !on_cur) begin
                        state <= IDLE;
                        ring  <= 1'b0;
                    end else if (sec_tick && sec_cnt == CW'(RING_SECS - 1)) begin
                        state <= IDLE;
                        ring  <= 1'b0;
`ifdef ACLK_SNOOZE_EN
                    end else if (snooze) begin
                        state   <= SNOOZE;
                        ring    <= 1'b0;
                        sec_cnt <= '0;
`endif
                    end else if (sec_tick) begin
                        sec_cnt <= sec_cnt + CW'(1);
                    end
                end
`ifdef ACLK_SNOOZE_EN
                SNOOZE: begin
                    if (STOP_al || !on_cur) begin
                        state <= IDLE;
                    end else if (sec_tick) begin
                        if (sec_cnt == CW'(SNOOZE_MIN * 60 - 1)) begin
                            state   <= RING;
                            ring    <= 1'b1;
                            sec_cnt <= '0;
                        end else begin
                            sec_cnt <= sec_cnt + CW'(1);
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    ring  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aclk_multi_alarm.sv
// tb/tb_aclk_multi_alarm.sv - self-checking bench for aclk_multi_alarm
module tb_aclk_multi_alarm;

    localparam int TPS = 4;
    localparam int NA  = 5;
    localparam int RS  = 60;
    localparam int SM  = 5;
    localparam int AW  = 3;
`ifdef ACLK_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [1:0]    H_in1 = '0;
    logic [3:0]    H_in0 = '0, M_in1 = '0, M_in0 = '0;
    logic          LD_time = 1'b0, LD_alarm = 1'b0;
    logic [AW-1:0] alarm_sel = '0;
    logic [NA-1:0] AL_ON = '0;
    logic          STOP_al = 1'b0, snooze = 1'b0;
    logic [1:0]    H_out1;
    logic [3:0]    H_out0, M_out1, M_out0, S_out1, S_out0;
    logic          ring, ld_err;
    logic [AW-1:0] ring_id;

    aclk_multi_alarm #(.TICKS_PER_SEC(TPS), .NUM_ALARMS(NA), .RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
        .clk(clk), .reset_n(reset_n), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .alarm_sel(alarm_sel), .AL_ON(AL_ON),
        .STOP_al(STOP_al), .snooze(snooze), .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1),
        .M_out0(M_out0), .S_out1(S_out1), .S_out0(S_out0), .ring(ring), .ring_id(ring_id), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: time as seconds of day, alarms as minutes of day, countdown in seconds
    int m_sec, m_presc, m_state, m_id, m_left;
    int m_alarm [NA];
    bit m_newmin, m_err;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_sec();
        return (int'(H_out1) * 10 + int'(H_out0)) * 3600 + (int'(M_out1) * 10 + int'(M_out0)) * 60 +
               int'(S_out1) * 10 + int'(S_out0);
    endfunction

    function automatic int dut_hm();
        return int'(H_out1) * 1000 + int'(H_out0) * 100 + int'(M_out1) * 10 + int'(M_out0);
    endfunction

    task automatic model_reset();
        m_sec = 0; m_presc = 0; m_state = 0; m_id = 0; m_left = 0; m_newmin = 0; m_err = 0;
        for (int i = 0; i < NA; i++) m_alarm[i] = 0;
    endtask

    task automatic model_step();
        bit tick, dig_ok, aok;
        int hh, mm, cur_min, match;
        tick    = (m_presc == TPS - 1);
        hh      = int'(H_in1) * 10 + int'(H_in0);
        mm      = int'(M_in1) * 10 + int'(M_in0);
        dig_ok  = (H_in0 <= 9) && (M_in0 <= 9) && (hh < 24) && (mm < 60);
        aok     = dig_ok && (int'(alarm_sel) < NA);
        cur_min = m_sec / 60;
        match   = -1;
        if (m_newmin)
            for (int i = 0; i < NA; i++)
                if (match < 0 && AL_ON[i] && m_alarm[i] == cur_min) match = i;
        case (m_state)
            0: if (match >= 0) begin m_state = 1; m_id = match; m_left = RS; end
            1: begin
                if (STOP_al || !AL_ON[m_id]) m_state = 0;
                else if (tick && m_left == 1) m_state = 0;
                else if (SNZ && snooze) begin m_state = 2; m_left = SM * 60; end
                else if (tick) m_left--;
            end
            default: begin
                if (STOP_al || !AL_ON[m_id]) m_state = 0;
                else if (tick) begin
                    m_left--;
                    if (m_left == 0) begin m_state = 1; m_left = RS; end
                end
            end
        endcase
        m_err = (LD_time && !dig_ok) || (!LD_time && LD_alarm && !aok);
        if (!LD_time && LD_alarm && aok) m_alarm[alarm_sel] = hh * 60 + mm;
        if (LD_time && dig_ok) begin
            m_sec = hh * 3600 + mm * 60; m_presc = 0; m_newmin = 0;
        end else begin
            if (tick) m_sec = (m_sec + 1) % 86400;
            m_newmin = tick && (m_sec % 60 == 0);
            m_presc  = tick ? 0 : m_presc + 1;
        end
    endtask

    task automatic compare_all();
        chk("model_time", dut_sec(), m_sec);
        chk("model_ring", ring, (m_state == 1) ? 1 : 0);
        chk("model_ld_err", ld_err, m_err);
        if (m_state != 0) chk("model_ring_id", ring_id, m_id);
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
    endtask

    task automatic set_digits(int h, int m);
        H_in1 = 2'(h / 10); H_in0 = 4'(h % 10); M_in1 = 4'(m / 10); M_in0 = 4'(m % 10);
    endtask

    task automatic load_time(int h, int m);
        set_digits(h, m); LD_time = 1'b1; step(); LD_time = 1'b0;
    endtask

    task automatic load_alarm(int sel, int h, int m);
        set_digits(h, m); alarm_sel = AW'(sel); LD_alarm = 1'b1; step(); LD_alarm = 1'b0;
    endtask

    task automatic wait_time(int target, int lim);
        int n = 0;
        while (dut_sec() != target && n < lim) begin step(); n++; end
        chk("wait_time", dut_sec(), target);
    endtask

    typedef struct {
        bit lt; bit la; int sel; int d1; int d0; int d2; int d3; bit e_err; int e_hm;
    } vec_t;
    vec_t vt [13];

    initial begin
        int n, t0;
        vt[0]  = '{1, 0, 0, 1, 2, 3, 4, 0, 1234};
        vt[1]  = '{1, 0, 0, 2, 4, 0, 0, 1, 1234};
        vt[2]  = '{1, 0, 0, 2, 4, 5, 0, 1, 1234};
        vt[3]  = '{1, 0, 0, 0, 9, 5, 10, 1, 1234};
        vt[4]  = '{1, 0, 0, 1, 9, 6, 0, 1, 1234};
        vt[5]  = '{1, 0, 0, 0, 10, 0, 0, 1, 1234};
        vt[6]  = '{1, 0, 0, 2, 3, 5, 9, 0, 2359};
        vt[7]  = '{0, 1, 5, 0, 7, 0, 0, 1, 2359};
        vt[8]  = '{0, 1, 7, 0, 7, 0, 0, 1, 2359};
        vt[9]  = '{0, 1, 4, 2, 3, 5, 9, 0, 2359};
        vt[10] = '{0, 1, 1, 3, 0, 0, 0, 1, 2359};
        vt[11] = '{1, 1, 5, 0, 0, 0, 0, 0, 0};
        vt[12] = '{1, 1, 2, 2, 5, 0, 0, 1, 0};

        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        chk("reset_time", dut_sec(), 0);
        chk("reset_ring", ring, 0);
        chk("reset_ring_id", ring_id, 0);
        chk("reset_ld_err", ld_err, 0);
        reset_n = 1'b1;

        step(10 * TPS);
        chk("ten_sec_s1", S_out1, 1);
        chk("ten_sec_s0", S_out0, 0);

        load_time(23, 59);
        step(60 * TPS);
        chk("midnight_wrap", dut_sec(), 0);

        for (int i = 0; i < 13; i++) begin
            H_in1 = 2'(vt[i].d1); H_in0 = 4'(vt[i].d0); M_in1 = 4'(vt[i].d2); M_in0 = 4'(vt[i].d3);
            alarm_sel = AW'(vt[i].sel); LD_time = vt[i].lt; LD_alarm = vt[i].la;
            step();
            LD_time = 1'b0; LD_alarm = 1'b0;
            chk($sformatf("vec%0d_err", i), ld_err, vt[i].e_err);
            chk($sformatf("vec%0d_hm", i), dut_hm(), vt[i].e_hm);
            step();
            chk($sformatf("vec%0d_err_pulse", i), ld_err, 0);
        end

        load_alarm(2, 7, 31);
        AL_ON = 5'b00100;
        load_time(7, 30);
        wait_time(27060, 61 * TPS);
        chk("ring_before_edge", ring, 0);
        step();
        chk("ring_rise", ring, 1);
        chk("ring_id_2", ring_id, 2);
        n = 0;
        while (ring === 1'b1 && n < 80 * TPS) begin n++; step(); end
        chk("ring_len", n, 60 * TPS - 1);

        load_alarm(0, 6, 0);
        load_alarm(3, 6, 0);
        AL_ON = 5'b01001;
        load_time(5, 59);
        wait_time(21600, 61 * TPS);
        step();
        chk("prio_ring", ring, 1);
        chk("prio_ring_id", ring_id, 0);
        STOP_al = 1'b1; step(); STOP_al = 1'b0;
        chk("stop_ring", ring, 0);

        load_time(6, 0);
        step(3 * TPS);
        chk("no_ring_on_load", ring, 0);

        load_time(5, 59);
        wait_time(21600, 61 * TPS);
        step();
        chk("ring_again", ring, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_ring", ring, 0);
        chk("async_reset_time", dut_sec(), 0);
        model_reset();
        @(posedge clk); #1 reset_n = 1'b1;

        load_alarm(1, 10, 0);
        AL_ON = 5'b00010;
        load_time(9, 59);
        wait_time(36000, 61 * TPS);
        step(4);
        chk("snz_ring", ring, 1);
`ifdef ACLK_SNOOZE_EN
        snooze = 1'b1; step(); snooze = 1'b0;
        chk("snooze_off", ring, 0);
        t0 = dut_sec();
        n = 0;
        while (ring === 1'b0 && n < 310 * TPS) begin n++; step(); end
        chk("snooze_len", dut_sec() - t0, SM * 60);
        chk("snooze_ring_id", ring_id, 1);
        STOP_al = 1'b1; step(); STOP_al = 1'b0;
        chk("snooze_stop", ring, 0);
        load_time(9, 59);
        wait_time(36000, 61 * TPS);
        step();
        STOP_al = 1'b1; snooze = 1'b1; step(); STOP_al = 1'b0; snooze = 1'b0;
        chk("stop_beats_snooze", ring, 0);
        step(301 * TPS);
        chk("stop_beats_snooze_later", ring, 0);
`else
        snooze = 1'b1; step(); snooze = 1'b0;
        chk("snooze_ignored", ring, 1);
        STOP_al = 1'b1; step(); STOP_al = 1'b0;
        chk("stop_no_snooze", ring, 0);
        t0 = dut_sec();
        step(2 * TPS);
        chk("time_runs", dut_sec() - t0, 2);
`endif

        for (int ep = 0; ep < 25; ep++) begin
            int h, m, nm, slot;
            h = $urandom_range(0, 23); m = $urandom_range(0, 59);
            slot = $urandom_range(0, NA - 1);
            for (int i = 0; i < NA; i++) load_alarm(i, $urandom_range(0, 23), $urandom_range(0, 59));
            nm = (h * 60 + m + 1) % 1440;
            load_alarm(slot, nm / 60, nm % 60);
            AL_ON = NA'($urandom);
            AL_ON[slot] = ($urandom_range(0, 3) != 0);
            load_time(h, m);
            repeat ($urandom_range(70, 90) * TPS) begin
                int r;
                STOP_al = ($urandom_range(0, 299) == 0);
                snooze  = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 499) == 0) AL_ON = NA'($urandom);
                r = $urandom_range(0, 399);
                if (r < 2) begin
                    H_in1 = 2'($urandom_range(0, 3)); H_in0 = 4'($urandom_range(0, 15));
                    M_in1 = 4'($urandom_range(0, 15)); M_in0 = 4'($urandom_range(0, 15));
                    alarm_sel = AW'($urandom_range(0, 7));
                    LD_time = (r == 0); LD_alarm = (r == 1);
                end
                step();
                STOP_al = 1'b0; snooze = 1'b0; LD_time = 1'b0; LD_alarm = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
